// File: rtl/ppu_reg_master.sv
// ppu_reg_master
//   CPU-side initiator for the PPU 8-register port. Each accepted request
//   becomes one chip-select cycle lasting DIV clocks. One rsp_valid pulse is
//   returned per access. A read also returns the data sampled on the last
//   clock of that cycle.
//   Separately, the PPU NMI line is synchronised. Each falling edge sets a
//   pending flag and increments a wrapping 8-bit counter.
//
// Ports
//   clk, rst_n                  clock / async active-low reset
//   req_valid/ready/write/addr/wdata
//                               single-access request channel
//   rsp_valid, rsp_rdata        completion pulse, last read data
//   ppu_cs_n/rw/addr/wdata/data_oe
//                               bus toward PPU (rw=1 means write)
//   ppu_rdata                   PPU read data
//   ppu_irq_n                   PPU NMI, async, active low
//   nmi_pending, nmi_ack        sticky NMI flag and its clear
//   nmi_count                   NMI edge count, wraps
module ppu_reg_master #(
  parameter int DIV   = 3,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ppu_cs_n,
  output logic       ppu_rw,
  output logic [2:0] ppu_addr,
  output logic [7:0] ppu_wdata,
  output logic       ppu_data_oe,
  input  logic [7:0] ppu_rdata,
  input  logic       ppu_irq_n,
  output logic       nmi_pending,
  input  logic       nmi_ack,
  output logic [7:0] nmi_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  typedef struct packed {
    logic       cs_n;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       oe;
  } bus_t;

  localparam bus_t             BUS_RST = '{cs_n: 1'b1, rw: 1'b0, addr: 3'd0, wdata: 8'h00, oe: 1'b0};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bus_t             bus_q, bus_d;
  logic [7:0]       rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bus_q   <= BUS_RST;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Bus fields are registered on the accept edge.
        // This makes cs_n fall on that same edge.
        if (req_valid) begin
          bus_d   = '{cs_n: 1'b0, rw: req_write, addr: req_addr, wdata: req_wdata, oe: req_write};
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // bus_q.rw still holds the access direction here.
          if (!bus_q.rw) rdata_d = ppu_rdata;
          // addr and wdata keep their values after the access ends.
          bus_d.cs_n = 1'b1;
          bus_d.oe   = 1'b0;
          bus_d.rw   = 1'b0;
          state_d    = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RELEASE);
  assign rsp_rdata   = rdata_q;
  assign ppu_cs_n    = bus_q.cs_n;
  assign ppu_rw      = bus_q.rw;
  assign ppu_addr    = bus_q.addr;
  assign ppu_wdata   = bus_q.wdata;
  assign ppu_data_oe = bus_q.oe;

  // NMI path: two-flop synchroniser, then prev flop for edge detection.
  logic irq_s1, irq_s2, irq_prev, irq_fall;
  logic nmi_pend_q;
  logic [7:0] nmi_cnt_q;

  assign irq_fall = irq_prev & ~irq_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1     <= 1'b1;
      irq_s2     <= 1'b1;
      irq_prev   <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_cnt_q  <= 8'h00;
    end else begin
      irq_s1   <= ppu_irq_n;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
      // A new edge wins over an ack in the same cycle, so no NMI is lost.
      if (irq_fall) begin
        nmi_pend_q <= 1'b1;
        nmi_cnt_q  <= nmi_cnt_q + 8'd1;
      end else if (nmi_ack) begin
        nmi_pend_q <= 1'b0;
      end
    end
  end

  assign nmi_pending = nmi_pend_q;
  assign nmi_count   = nmi_cnt_q;

endmodule
